// File: rtl/lcd_init_seq_if.sv
// ---------------------------------------------------------------------------
// lcd_init_seq_if
//
// Purpose: command handshake between the HD44780-style init sequencer and
// the bus writer that drives the LCD pins.
//
// Signals:
//   cmd_valid  sequencer -> writer  transfer request, held until cmd_done
//   cmd_data   sequencer -> writer  transfer value (4-bit mode uses [3:0])
//   read_busy  sequencer -> writer  writer polls BF after this transfer
//   cmd_done   writer -> sequencer  one-cycle pulse, transfer (and any busy
//                                   poll) complete
//
// Modports:
//   master  the sequencer side
//   slave   the bus writer side
// ---------------------------------------------------------------------------
interface lcd_init_seq_if;

    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       read_busy;
    logic       cmd_done;

    modport master (
        output cmd_valid,
        output cmd_data,
        output read_busy,
        input  cmd_done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        input  read_busy,
        output cmd_done
    );

endinterface

// File: rtl/lcd_init_seq.sv
// ---------------------------------------------------------------------------
// lcd_init_seq
//
// Purpose: power-on initialisation sequencer for an HD44780-compatible
// character LCD. After start_init it waits for the panel power-up time,
// issues the three "function set 8-bit" wake-up transfers with their
// datasheet delays, optionally switches the panel into 4-bit mode, then
// sends function set, display off, clear, entry mode and display on.
// Each transfer is handed to an external bus writer over a valid/done
// handshake; a per-transfer watchdog catches a writer that never answers.
//
// Ports:
//   CLK             clock
//   RESET_N         asynchronous active-low reset
//   start_init      start request (honoured only when idle, done or failed)
//   bus             lcd_init_seq_if.master: cmd_valid/cmd_data/read_busy out,
//                   cmd_done in
//   busy            sequence in progress
//   init_done       level, sequence completed
//   init_done_tick  one-cycle pulse on completion
//   init_error      level, writer timed out
//   step            index of the current transfer
// ---------------------------------------------------------------------------
module lcd_init_seq #(
    parameter bit BUS8        = 1'b0,
    parameter bit TWO_LINES   = 1'b1,
    parameter bit FONT_5X10   = 1'b0,
    parameter bit CURSOR_ON   = 1'b0,
    parameter bit BLINK_ON    = 1'b0,
    parameter bit ENTRY_INC   = 1'b1,
    parameter bit ENTRY_SHIFT = 1'b0,
    parameter bit USE_BUSY    = 1'b1,
    parameter int POWERUP_CYCLES = 750000,
    parameter int WAKE1_CYCLES   = 205000,
    parameter int WAKE_CYCLES    = 5000,
    parameter int CMD_CYCLES     = 2000,
    parameter int CLEAR_CYCLES   = 82000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 start_init,
    lcd_init_seq_if.master       bus,
    output logic                 busy,
    output logic                 init_done,
    output logic                 init_done_tick,
    output logic                 init_error,
    output logic [4:0]           step
);

    // Command bytes assembled from the configuration bits.
    localparam logic [7:0] FS = 8'h20 | (BUS8        ? 8'h10 : 8'h00)
                                      | (TWO_LINES   ? 8'h08 : 8'h00)
                                      | (FONT_5X10   ? 8'h04 : 8'h00);
    localparam logic [7:0] EM = 8'h04 | (ENTRY_INC   ? 8'h02 : 8'h00)
                                      | (ENTRY_SHIFT ? 8'h01 : 8'h00);
    localparam logic [7:0] DC = 8'h0C | (CURSOR_ON   ? 8'h02 : 8'h00)
                                      | (BLINK_ON    ? 8'h01 : 8'h00);

    localparam int         NUM_XFERS = BUS8 ? 8 : 14;
    localparam logic [4:0] LAST_STEP = 5'(NUM_XFERS - 1);
    localparam logic [4:0] END_STEP  = 5'(NUM_XFERS);

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Both counters only ever hold (delay - 1) down to 0, so the largest
    // delay parameter fixes the width and no value can wrap.
    localparam int MAX_DELAY = maxInt(maxInt(maxInt(POWERUP_CYCLES, WAKE1_CYCLES),
                                             maxInt(WAKE_CYCLES, CMD_CYCLES)),
                                      maxInt(CLEAR_CYCLES, TIMEOUT_CYCLES));
    localparam int CW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PWR_WAIT,
        ISSUE,
        GAP,
        DONE,
        ERROR
    } stateType;

    stateType      state;
    logic [CW-1:0] delayCnt;
    logic [CW-1:0] wdogCnt;
    logic          cmdValidQ;
    logic [7:0]    cmdDataQ;
    logic          readBusyQ;

    int            curGap;
    logic          gapNone;
    logic [CW-1:0] gapLoad;

    // A "final" transfer is one that completes an instruction inside the
    // controller: every byte after the wakes in 8-bit mode, and in 4-bit
    // mode the single-nibble switch (step 3) plus each low nibble.
    function automatic logic isFinalXfer(input logic [4:0] s);
        if (BUS8)
            return (s >= 5'd3);
        else
            return (s >= 5'd3) && s[0];
    endfunction

    function automatic logic isClearXfer(input logic [4:0] s);
        return BUS8 ? (s == 5'd5) : (s == 5'd9);
    endfunction

    function automatic logic [7:0] xferData(input logic [4:0] s);
        logic [7:0] d;
        d = 8'h00;
        if (BUS8) begin
            case (s)
                5'd0, 5'd1, 5'd2: d = 8'h30;
                5'd3:             d = FS;
                5'd4:             d = 8'h08;
                5'd5:             d = 8'h01;
                5'd6:             d = EM;
                5'd7:             d = DC;
                default:          d = 8'h00;
            endcase
        end else begin
            case (s)
                5'd0, 5'd1, 5'd2: d = 8'h03;
                5'd3:             d = 8'h02;
                5'd4:             d = {4'h0, FS[7:4]};
                5'd5:             d = {4'h0, FS[3:0]};
                5'd7:             d = 8'h08;
                5'd9:             d = 8'h01;
                5'd11:            d = {4'h0, EM[3:0]};
                5'd13:            d = {4'h0, DC[3:0]};
                default:          d = 8'h00;
            endcase
        end
        return d;
    endfunction

    // High nibbles never need a delay: the controller only acts once the
    // low nibble has arrived.
    function automatic int gapCycles(input logic [4:0] s);
        int g;
        g = 0;
        if (s == 5'd0)
            g = WAKE1_CYCLES;
        else if (s == 5'd1 || s == 5'd2)
            g = WAKE_CYCLES;
        else if (isFinalXfer(s) && !USE_BUSY)
            g = isClearXfer(s) ? CLEAR_CYCLES : CMD_CYCLES;
        return g;
    endfunction

    // Gap that follows the transfer currently being issued.
    always_comb begin
        curGap  = gapCycles(step);
        gapNone = (curGap == 0);
        gapLoad = CW'(curGap - 1);
    end

    assign bus.cmd_valid = cmdValidQ;
    assign bus.cmd_data  = cmdDataQ;
    assign bus.read_busy = readBusyQ;

    // Sequencer FSM. ISSUE covers both the live request (cmdValidQ=1) and a
    // one-cycle setup slot (cmdValidQ=0) used when a transfer is followed
    // directly by the next one, so the writer always sees valid drop after
    // cmd_done. A transfer with a delay waits in GAP and then raises valid
    // directly on leaving it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= IDLE;
            delayCnt       <= '0;
            wdogCnt        <= '0;
            cmdValidQ      <= 1'b0;
            cmdDataQ       <= 8'h00;
            readBusyQ      <= 1'b0;
            busy           <= 1'b0;
            init_done      <= 1'b0;
            init_done_tick <= 1'b0;
            init_error     <= 1'b0;
            step           <= 5'd0;
        end else begin
            init_done_tick <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start_init) begin
                        state      <= PWR_WAIT;
                        step       <= 5'd0;
                        init_done  <= 1'b0;
                        init_error <= 1'b0;
                        busy       <= 1'b1;
                        delayCnt   <= CW'(POWERUP_CYCLES - 1);
                    end
                end

                PWR_WAIT: begin
                    if (delayCnt == '0) begin
                        state     <= ISSUE;
                        cmdValidQ <= 1'b1;
                        cmdDataQ  <= xferData(step);
                        readBusyQ <= USE_BUSY && isFinalXfer(step);
                        wdogCnt   <= '0;
                    end else begin
                        delayCnt <= delayCnt - CW'(1);
                    end
                end

                ISSUE: begin
                    if (!cmdValidQ) begin
                        cmdValidQ <= 1'b1;
                        cmdDataQ  <= xferData(step);
                        readBusyQ <= USE_BUSY && isFinalXfer(step);
                        wdogCnt   <= '0;
                    end else if (bus.cmd_done) begin
                        cmdValidQ <= 1'b0;
                        wdogCnt   <= '0;
                        step      <= step + 5'd1;
                        if (!gapNone) begin
                            state    <= GAP;
                            delayCnt <= gapLoad;
                        end else if (step == LAST_STEP) begin
                            state          <= DONE;
                            busy           <= 1'b0;
                            init_done      <= 1'b1;
                            init_done_tick <= 1'b1;
                        end
                    end else if (wdogCnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state      <= ERROR;
                        cmdValidQ  <= 1'b0;
                        busy       <= 1'b0;
                        init_error <= 1'b1;
                        wdogCnt    <= '0;
                    end else begin
                        wdogCnt <= wdogCnt + CW'(1);
                    end
                end

                // step already points at the next transfer here.
                GAP: begin
                    if (delayCnt == '0) begin
                        if (step == END_STEP) begin
                            state          <= DONE;
                            busy           <= 1'b0;
                            init_done      <= 1'b1;
                            init_done_tick <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            cmdValidQ <= 1'b1;
                            cmdDataQ  <= xferData(step);
                            readBusyQ <= USE_BUSY && isFinalXfer(step);
                            wdogCnt   <= '0;
                        end
                    end else begin
                        delayCnt <= delayCnt - CW'(1);
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmdValidQ <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_init_seq.sv
// ---------------------------------------------------------------------------
// tb_lcd_init_seq
//
// Purpose: self-checking bench for lcd_init_seq. Two instances are built:
// A is a 4-bit bus with busy polling, B is an 8-bit bus with fixed delays.
// The expected transfer list is derived from the command bytes; the writer
// answers each request after a random number of cycles.
// ---------------------------------------------------------------------------
module tb_lcd_init_seq;

    localparam int P_POWER   = 4;
    localparam int P_WAKE1   = 3;
    localparam int P_WAKE    = 2;
    localparam int P_CMD     = 2;
    localparam int P_CLEAR   = 5;
    localparam int P_TIMEOUT = 8;

    localparam bit TB_TWO_LINES = 1'b1;
    localparam bit TB_FONT      = 1'b0;
    localparam bit TB_CURSOR    = 1'b0;
    localparam bit TB_BLINK     = 1'b0;
    localparam bit TB_INC       = 1'b1;
    localparam bit TB_SHIFT     = 1'b0;

    typedef struct {
        int         respDelay;
        logic [7:0] expData;
        logic       expRb;
        int         expGap;
    } vecType;

    logic       CLK;
    logic       RESET_N;
    logic       startA, startB;
    logic       busyA, doneA, tickA, errA;
    logic       busyB, doneB, tickB, errB;
    logic [4:0] stepA, stepB;

    lcd_init_seq_if busA ();
    lcd_init_seq_if busB ();

    lcd_init_seq #(
        .BUS8(1'b0), .TWO_LINES(TB_TWO_LINES), .FONT_5X10(TB_FONT),
        .CURSOR_ON(TB_CURSOR), .BLINK_ON(TB_BLINK), .ENTRY_INC(TB_INC),
        .ENTRY_SHIFT(TB_SHIFT), .USE_BUSY(1'b1),
        .POWERUP_CYCLES(P_POWER), .WAKE1_CYCLES(P_WAKE1), .WAKE_CYCLES(P_WAKE),
        .CMD_CYCLES(P_CMD), .CLEAR_CYCLES(P_CLEAR), .TIMEOUT_CYCLES(P_TIMEOUT)
    ) dutA (
        .CLK(CLK), .RESET_N(RESET_N), .start_init(startA), .bus(busA),
        .busy(busyA), .init_done(doneA), .init_done_tick(tickA),
        .init_error(errA), .step(stepA)
    );

    lcd_init_seq #(
        .BUS8(1'b1), .TWO_LINES(TB_TWO_LINES), .FONT_5X10(TB_FONT),
        .CURSOR_ON(TB_CURSOR), .BLINK_ON(TB_BLINK), .ENTRY_INC(TB_INC),
        .ENTRY_SHIFT(TB_SHIFT), .USE_BUSY(1'b0),
        .POWERUP_CYCLES(P_POWER), .WAKE1_CYCLES(P_WAKE1), .WAKE_CYCLES(P_WAKE),
        .CMD_CYCLES(P_CMD), .CLEAR_CYCLES(P_CLEAR), .TIMEOUT_CYCLES(P_TIMEOUT)
    ) dutB (
        .CLK(CLK), .RESET_N(RESET_N), .start_init(startB), .bus(busB),
        .busy(busyB), .init_done(doneB), .init_done_tick(tickB),
        .init_error(errB), .step(stepB)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int     errCnt = 0;
    int     chkCnt = 0;
    bit     dutSel = 1'b0;
    bit     strayOn = 1'b0;
    vecType vecs[$];

    logic       obsValid, obsRb, obsBusy, obsDone, obsTick, obsErr;
    logic [7:0] obsData;
    logic [4:0] obsStep;

    // Route the selected instance onto one set of observation signals.
    always_comb begin
        if (dutSel) begin
            obsValid = busB.cmd_valid; obsData = busB.cmd_data; obsRb = busB.read_busy;
            obsBusy  = busyB; obsDone = doneB; obsTick = tickB; obsErr = errB; obsStep = stepB;
        end else begin
            obsValid = busA.cmd_valid; obsData = busA.cmd_data; obsRb = busA.read_busy;
            obsBusy  = busyA; obsDone = doneA; obsTick = tickA; obsErr = errA; obsStep = stepA;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic setStart(input logic v);
        if (dutSel) startB = v; else startA = v;
    endtask

    task automatic setDone(input logic v);
        if (dutSel) busB.cmd_done = v; else busA.cmd_done = v;
    endtask

    task automatic addVec(input logic [7:0] data, input logic rb, input int gap);
        vecType r;
        r.respDelay = int'($urandom_range(0, 4));
        r.expData   = data;
        r.expRb     = rb;
        r.expGap    = gap;
        vecs.push_back(r);
    endtask

    // Reference list: three wakes, the 4-bit switch when on a nibble bus,
    // then five commands, each either one byte or a high/low nibble pair.
    // Only the transfer that completes a command gets read_busy or a delay.
    task automatic buildVectors(input bit bus8, input bit useBusy);
        logic [7:0] fs, em, dc;
        logic [7:0] cmds [5];
        int         finalGap;
        fs = 8'h20 | (bus8 ? 8'h10 : 8'h00) | (TB_TWO_LINES ? 8'h08 : 8'h00)
                   | (TB_FONT ? 8'h04 : 8'h00);
        em = 8'h04 | (TB_INC ? 8'h02 : 8'h00) | (TB_SHIFT ? 8'h01 : 8'h00);
        dc = 8'h0C | (TB_CURSOR ? 8'h02 : 8'h00) | (TB_BLINK ? 8'h01 : 8'h00);
        cmds = '{fs, 8'h08, 8'h01, em, dc};
        vecs.delete();
        for (int w = 0; w < 3; w++)
            addVec(bus8 ? 8'h30 : 8'h03, 1'b0, (w == 0) ? P_WAKE1 : P_WAKE);
        if (!bus8)
            addVec(8'h02, useBusy, useBusy ? 0 : P_CMD);
        for (int c = 0; c < 5; c++) begin
            finalGap = useBusy ? 0 : ((cmds[c] == 8'h01) ? P_CLEAR : P_CMD);
            if (bus8) begin
                addVec(cmds[c], useBusy, finalGap);
            end else begin
                addVec({4'h0, cmds[c][7:4]}, 1'b0, 0);
                addVec({4'h0, cmds[c][3:0]}, useBusy, finalGap);
            end
        end
    endtask

    // Pulse start_init and measure the power-up wait up to the first request.
    task automatic startAndPower();
        int cnt;
        setStart(1'b1);
        @(negedge CLK);
        setStart(1'b0);
        checkOutput("busy_after_start", 32'(obsBusy), 1);
        checkOutput("init_done_cleared", 32'(obsDone), 0);
        checkOutput("init_error_cleared", 32'(obsErr), 0);
        checkOutput("step_after_start", 32'(obsStep), 0);
        cnt = 0;
        while (!obsValid && cnt < 200) begin
            cnt++;
            @(negedge CLK);
        end
        checkOutput("powerup_cycles", 32'(cnt), 32'(P_POWER));
    endtask

    // Entered on a falling edge with the request for vecs[idx] showing.
    task automatic applyStimulus(input int idx);
        vecType     v;
        bit         last;
        bit         stable;
        int         cnt;
        logic [7:0] held;
        v    = vecs[idx];
        last = (idx == vecs.size() - 1);
        checkOutput($sformatf("valid_s%0d", idx), 32'(obsValid), 1);
        checkOutput($sformatf("data_s%0d", idx), 32'(obsData), 32'(v.expData));
        checkOutput($sformatf("read_busy_s%0d", idx), 32'(obsRb), 32'(v.expRb));
        checkOutput($sformatf("step_s%0d", idx), 32'(obsStep), 32'(idx));
        held   = obsData;
        stable = 1'b1;
        for (int d = 0; d < v.respDelay; d++) begin
            if (strayOn && $urandom_range(0, 1) == 1) setStart(1'b1);
            @(negedge CLK);
            setStart(1'b0);
            if (obsValid !== 1'b1 || obsData !== held) stable = 1'b0;
        end
        checkOutput($sformatf("hold_s%0d", idx), 32'(stable), 1);
        setDone(1'b1);
        @(negedge CLK);
        setDone(1'b0);
        checkOutput($sformatf("valid_drop_s%0d", idx), 32'(obsValid), 0);
        checkOutput($sformatf("step_inc_s%0d", idx), 32'(obsStep), 32'(idx + 1));
        cnt = 0;
        if (!last) begin
            while (!obsValid && cnt < 200) begin
                cnt++;
                if (strayOn && $urandom_range(0, 2) == 0) setDone(1'b1);
                @(negedge CLK);
                setDone(1'b0);
            end
            checkOutput($sformatf("gap_s%0d", idx), 32'(cnt), 32'((v.expGap > 0) ? v.expGap : 1));
        end else begin
            while (!obsTick && cnt < 200) begin
                cnt++;
                @(negedge CLK);
            end
            checkOutput("done_delay", 32'(cnt), 32'(v.expGap));
            checkOutput("init_done_set", 32'(obsDone), 1);
            checkOutput("busy_after_done", 32'(obsBusy), 0);
            checkOutput("valid_after_done", 32'(obsValid), 0);
            @(negedge CLK);
            checkOutput("tick_one_cycle", 32'(obsTick), 0);
            checkOutput("init_done_held", 32'(obsDone), 1);
            checkOutput("final_step", 32'(obsStep), 32'(vecs.size()));
        end
    endtask

    task automatic runFull();
        startAndPower();
        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(i);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: actual=expired required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int  cnt;
        bit  saw;
        RESET_N      = 1'b0;
        startA       = 1'b0;
        startB       = 1'b0;
        busA.cmd_done = 1'b0;
        busB.cmd_done = 1'b0;

        // Reset values on both instances.
        repeat (3) @(negedge CLK);
        for (int s = 0; s < 2; s++) begin
            dutSel = bit'(s);
            #1;
            checkOutput($sformatf("rst_valid_%0d", s), 32'(obsValid), 0);
            checkOutput($sformatf("rst_data_%0d", s), 32'(obsData), 0);
            checkOutput($sformatf("rst_busy_%0d", s), 32'(obsBusy), 0);
            checkOutput($sformatf("rst_step_%0d", s), 32'(obsStep), 0);
            checkOutput($sformatf("rst_done_%0d", s), 32'(obsDone), 0);
            checkOutput($sformatf("rst_err_%0d", s), 32'(obsErr), 0);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        // 4-bit bus with busy polling, stray start/done injected.
        $display("[TB] 4-bit busy-poll sequence");
        dutSel  = 1'b0;
        strayOn = 1'b1;
        buildVectors(1'b0, 1'b1);
        runFull();

        // 8-bit bus with fixed delays.
        $display("[TB] 8-bit fixed-delay sequence");
        dutSel = 1'b1;
        buildVectors(1'b1, 1'b0);
        runFull();

        // Writer never answers step 2.
        $display("[TB] watchdog timeout");
        dutSel  = 1'b0;
        strayOn = 1'b0;
        buildVectors(1'b0, 1'b1);
        startAndPower();
        applyStimulus(0);
        applyStimulus(1);
        checkOutput("step_before_timeout", 32'(obsStep), 2);
        cnt = 0;
        while (obsValid && cnt < 200) begin
            cnt++;
            @(negedge CLK);
        end
        checkOutput("timeout_valid_cycles", 32'(cnt), 32'(P_TIMEOUT));
        checkOutput("timeout_error", 32'(obsErr), 1);
        checkOutput("timeout_busy", 32'(obsBusy), 0);
        checkOutput("timeout_done", 32'(obsDone), 0);
        setDone(1'b1);
        @(negedge CLK);
        setDone(1'b0);
        @(negedge CLK);
        checkOutput("late_done_step", 32'(obsStep), 2);
        checkOutput("late_done_error", 32'(obsErr), 1);

        // Restart after the error, then reset in the middle of step 6.
        $display("[TB] restart and mid-sequence reset");
        startAndPower();
        for (int i = 0; i < 6; i++)
            applyStimulus(i);
        checkOutput("step_before_reset", 32'(obsStep), 6);
        RESET_N = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(obsValid), 0);
        checkOutput("async_rst_data", 32'(obsData), 0);
        checkOutput("async_rst_rb", 32'(obsRb), 0);
        checkOutput("async_rst_busy", 32'(obsBusy), 0);
        checkOutput("async_rst_step", 32'(obsStep), 0);
        checkOutput("async_rst_err", 32'(obsErr), 0);
        checkOutput("async_rst_done", 32'(obsDone), 0);
        checkOutput("async_rst_tick", 32'(obsTick), 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (obsValid !== 1'b0 || obsBusy !== 1'b0) saw = 1'b1;
        end
        checkOutput("quiet_after_reset", 32'(saw), 0);
        strayOn = 1'b1;
        buildVectors(1'b0, 1'b1);
        runFull();

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
